// File: rtl/divider_if.sv
// divider_if: request operands and result/status bundle for the divider.
interface divider_if #(
    parameter int W = 16
);
    logic start;
    logic [2*W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic busy;
    logic done;
    logic overflow;
    modport master(output start, dividend, divisor, input quotient, remainder, busy, done, overflow);
    modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, overflow);
endinterface

// File: rtl/divider.sv
// divider: unsigned restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per cycle.
module divider #(
    parameter int W = 16
) (
    input logic clk,
    input logic reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    typedef enum logic {IDLE, CALC} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [W-1:0] hi, lo, dvs, pr, pr_next, q, quotient, remainder;
    logic [W:0] shifted;
    logic take, ovf_req, last, qbit, done, overflow;
    assign take = state == IDLE && bus.start;
    assign ovf_req = bus.divisor <= bus.dividend[2*W-1:W];
    assign last = cnt == CW'(W - 1);
    // first step seeds the working remainder with the dividend's upper half
    assign shifted = {(cnt == '0) ? hi : pr, lo[W-1]};
    assign qbit = shifted >= {1'b0, dvs};
    assign pr_next = qbit ? W'(shifted - {1'b0, dvs}) : shifted[W-1:0];
    always_ff @(posedge clk) state <= reset ? IDLE : next_state;
    always_comb next_state = (state == IDLE) ? ((take && !ovf_req) ? CALC : IDLE) : (last ? IDLE : CALC);
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            dvs <= '0;
            pr <= '0;
            q <= '0;
            quotient <= '0;
            remainder <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                overflow <= ovf_req;
                done <= ovf_req;
                hi <= bus.dividend[2*W-1:W];
                lo <= bus.dividend[W-1:0];
                dvs <= bus.divisor;
                pr <= '0;
                cnt <= '0;
                q <= '0;
            end else if (state == CALC) begin
                pr <= pr_next;
                lo <= lo << 1;
                q <= {q[W-2:0], qbit};
                cnt <= cnt + 1'b1;
                if (last) begin
                    quotient <= {q[W-2:0], qbit};
                    remainder <= pr_next;
                    done <= 1'b1;
                end
            end
        end
    end
    assign bus.quotient = quotient;
    assign bus.remainder = remainder;
    assign bus.busy = state == CALC;
    assign bus.done = done;
    assign bus.overflow = overflow;
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the width of the divisor, quotient and remainder; the dividend is 2W bits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend  input  2W  unsigned dividend; sampled on the accepting edge only.
REQ-006 The block SHALL have port divisor  input  W  unsigned divisor; sampled on the accepting edge only.
REQ-007 The block SHALL have port quotient  output  W  unsigned quotient of the last successful division.
REQ-008 The block SHALL have port remainder  output  W  unsigned remainder of the last successful division.
REQ-009 The block SHALL have port busy  output  1  high while in CALC.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port overflow  output  1  high when the last accepted request overflowed.

Function
REQ-012 The block SHALL implement exactly two states, IDLE and CALC; busy SHALL be 1 if and only if the state is CALC.
REQ-013 In IDLE, start=1 SHALL be accepted on that edge; in CALC, start SHALL be ignored.
REQ-014 On acceptance, overflow SHALL be cleared, except that an overflow acceptance sets it per REQ-015.
REQ-015 Overflow check at acceptance: if divisor <= dividend[2W-1:W] (this includes divisor=0), the block SHALL stay in IDLE and set overflow=1 and done=1 for the next cycle.
REQ-016 On an overflow acceptance, quotient and remainder SHALL remain unchanged.
REQ-017 Otherwise, the accepting edge SHALL latch the operands, zero a (W+1)-bit partial remainder and the iteration counter, and enter CALC.
REQ-018 Each CALC edge SHALL perform one restoring step, dividend MSB first.
REQ-019 Restoring step: shift the next dividend bit into the partial remainder, which is seeded with dividend[2W-1:W] at the first step.
REQ-020 Restoring step, continued: if the partial remainder >= divisor, subtract the divisor and shift quotient bit 1; else shift quotient bit 0.
REQ-021 After exactly W CALC edges, the block SHALL return to IDLE, drive quotient and remainder (the low W bits of the partial remainder), and assert done for the following cycle.
REQ-022 Latency SHALL be W cycles from the accepting edge to done high for a normal division, and 1 cycle for an overflow.
REQ-023 done SHALL be high for exactly one cycle per accepted request and never otherwise.
REQ-024 A start asserted in the cycle where done is high SHALL be accepted, giving back-to-back operation with no dead cycle.
REQ-025 quotient, remainder and overflow SHALL hold their values until the next acceptance or completion updates them.
REQ-026 Operand inputs changing during CALC SHALL have no effect on the result.
REQ-027 All arithmetic SHALL be unsigned, with no sign handling; the partial remainder SHALL never exceed W+1 bits.

Reset
REQ-028 reset=1 SHALL have priority over all other inputs on the same edge.
REQ-029 On reset: state=IDLE; quotient=0; remainder=0; busy=0; done=0; overflow=0; internal counters and registers cleared.
REQ-030 reset asserted mid-CALC SHALL abort the operation with no done pulse; a start in the first cycle after reset is released SHALL be accepted.

Verification
REQ-031 Scenario: W=16, dividend=0x0000_0064, divisor=0x0007 -> done exactly 16 cycles after acceptance, quotient=0x000E, remainder=0x0002, overflow=0, busy high for 16 cycles.
REQ-032 Scenario: divisor=0x0000 with prior quotient=0x000E -> done and overflow high 1 cycle later, busy never high, quotient still 0x000E.
REQ-033 Scenario: dividend=0x0005_0000 with divisor=0x0005 -> overflow=1; with divisor=0x0006 -> quotient=0xD555, remainder=0x0002, overflow=0.
REQ-034 Scenario: dividend=0xFFFE_FFFF, divisor=0xFFFF -> quotient=0xFFFF, remainder=0xFFFE.
REQ-035 Scenario: reset pulsed 8 cycles into CALC -> busy=0 next cycle, no done pulse, all outputs 0.
REQ-036 Scenario: start held continuously, with operands changed mid-CALC -> the second request is accepted in the done cycle of the first, its result is correct, and the first result is unaffected by the operand change.
